gshare_index_gen: RTL and testbench
===================================

Name: gshare_index_gen

Overview:
Upstream companion of the 2-bit-counter pattern history table. It holds the speculative global history register (GHR) and forms the gshare read index from fetch PC XOR GHR. It queues in-flight predictions in order, so that at branch resolution it drives the table's update index, enable and outcome. On a misprediction it flushes wrong-path entries and repairs the GHR.

Parameters:
INDEX_WIDTH, 12, width of PHT index and of the GHR
PC_LSB, 2, lowest PC bit used in the index (drops byte offset)
DEPTH, 4, in-flight branch queue depth; power of 2, >= 2

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
fetch_valid_i  in  1  conditional branch being predicted this cycle
fetch_pc_i  in  32  PC of that branch
pht_prediction_i  in  1  PHT prediction bit for rd_index_o, async read, same cycle
rd_index_o  out  INDEX_WIDTH  combinational: fetch_pc_i[PC_LSB +: INDEX_WIDTH] ^ spec_ghr
pred_taken_o  out  1  fetch_valid_i & pht_prediction_i
fetch_stall_o  out  1  queue full (count == DEPTH), registered-state based
resolve_valid_i  in  1  oldest in-flight branch resolved (in order)
resolve_taken_i  in  1  actual outcome of that branch
update_en_o  out  1  PHT update enable, registered
update_index_o  out  INDEX_WIDTH  PHT update index, registered
br_taken_o  out  1  outcome to PHT, registered
mispredict_o  out  1  pulse; resolved outcome != queued prediction, registered

Behaviour:
- Reset (async, rst_i low): spec_ghr = 0, commit_ghr = 0, queue empty (count 0, pointers 0). update_en_o, update_index_o, br_taken_o and mispredict_o are all 0. Reset mid-operation discards all in-flight entries.
- Accept: accept = fetch_valid_i & ~fetch_stall_o.
  - On accept, push {rd_index_o, pht_prediction_i} at the tail.
  - spec_ghr <= {spec_ghr[INDEX_WIDTH-2:0], pht_prediction_i}.
- Fetch while full is not pushed and spec_ghr is unchanged. The upstream holds fetch on fetch_stall_o.
- A same-cycle pop does not lift the stall; there is no full bypass.
- Resolve:
  - Resolve is effective when resolve_valid_i and count != 0. Pop the head.
  - Next cycle: update_en_o = 1, update_index_o = head.index, br_taken_o = resolve_taken_i, mispredict_o = (head.pred != resolve_taken_i).
  - commit_ghr <= {commit_ghr[INDEX_WIDTH-2:0], resolve_taken_i}.
- Resolve on empty queue is ignored: update_en_o = 0 and no state change.
- Outputs are single-cycle. update_en_o and mispredict_o return to 0 unless another resolve occurs.
- Mispredict (detected combinationally at the effective resolve):
  - Flush the whole queue: count = 0, head = tail. All remaining entries are younger and wrong-path.
  - spec_ghr <= {commit_ghr[INDEX_WIDTH-2:0], resolve_taken_i}.
  - Recovery has priority: a fetch accepted in the same cycle is dropped (not pushed, no GHR shift).
- Correct resolve with a simultaneous accept: push and pop both occur, count unchanged, spec_ghr shifts normally.
- Pointer wrap-around modulo DEPTH; count width clog2(DEPTH)+1.
- The PHT update lands one cycle after resolve. A same-cycle read of that index sees the old counter; this is accepted by design.

Decomposition:
- bp_pkg: default INDEX_WIDTH, PHT counter state constants (shared with the PHT), queue-entry field layout constants.
- Sub-module bp_inflight_fifo: in-order queue with push, pop, flush, full and empty, parameterised on width and DEPTH.
- gshare_index_gen: GHR registers, index XOR, resolve/update output registers, recovery.

Test Plan:
(INDEX_WIDTH=4, PC_LSB=2, DEPTH=4)
1. Reset release, fetch_pc_i=0x34 -> rd_index_o=0xD. All registered outputs 0, fetch_stall_o=0.
2. Three accepted fetches at pc 0x34 with predictions 1,0,1 -> indices pushed 0xD, 0xC, 0xF. spec_ghr=0101, then rd_index_o=0x8.
3. Resolve taken (head pred 1) -> next cycle update_en_o=1, update_index_o=0xD, br_taken_o=1, mispredict_o=0. commit_ghr=0001.
4. Resolve taken (head pred 0), plus a fetch the same cycle -> next cycle update_index_o=0xC, mispredict_o=1. Queue empty; fetch dropped; spec_ghr=0011.
5. Four fetches -> fetch_stall_o=1. A fifth fetch is not pushed and spec_ghr is unchanged. Pop plus fetch in the same cycle: no push that cycle.
6. resolve_valid_i with empty queue -> update_en_o stays 0. Assert rst_i low with 3 entries queued -> count 0, GHRs 0, outputs 0 immediately.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: default sizes, PHT counter encodings
// and the layout of an in-flight prediction entry.
package bp_pkg;

  localparam int unsigned BP_INDEX_WIDTH_DEF = 12;
  localparam int unsigned BP_PC_LSB_DEF      = 2;
  localparam int unsigned BP_DEPTH_DEF       = 4;

  // 2-bit saturating counter states; MSB is the taken prediction
  localparam logic [1:0] PHT_STRONG_NT = 2'b00;
  localparam logic [1:0] PHT_WEAK_NT   = 2'b01;
  localparam logic [1:0] PHT_WEAK_T    = 2'b10;
  localparam logic [1:0] PHT_STRONG_T  = 2'b11;

  // In-flight entry: {index, pred}, prediction in bit 0
  localparam int unsigned ENTRY_PRED_BIT = 0;
  localparam int unsigned ENTRY_IDX_LSB  = 1;

  function automatic int unsigned entry_width(input int unsigned index_width);
    return index_width + 1;
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// In-order queue of in-flight predictions with push, pop and whole-queue flush.
// Flush wins over push/pop; push when full and pop when empty are ignored.
module bp_inflight_fifo #(
  parameter int unsigned WIDTH = 13,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  // Pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gshare_index_gen.sv
// Gshare front end: speculative/committed GHR, PC^GHR read index, in-order
// resolve to PHT update, and GHR repair with wrong-path flush on mispredict.
module gshare_index_gen
  import bp_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = BP_INDEX_WIDTH_DEF,
  parameter int unsigned PC_LSB      = BP_PC_LSB_DEF,
  parameter int unsigned DEPTH       = BP_DEPTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   fetch_valid_i,
  input  logic [31:0]            fetch_pc_i,
  input  logic                   pht_prediction_i,
  output logic [INDEX_WIDTH-1:0] rd_index_o,
  output logic                   pred_taken_o,
  output logic                   fetch_stall_o,
  input  logic                   resolve_valid_i,
  input  logic                   resolve_taken_i,
  output logic                   update_en_o,
  output logic [INDEX_WIDTH-1:0] update_index_o,
  output logic                   br_taken_o,
  output logic                   mispredict_o
);

  localparam int unsigned ENTRY_W = entry_width(INDEX_WIDTH);

  logic [INDEX_WIDTH-1:0] spec_ghr_q, spec_ghr_d;
  logic [INDEX_WIDTH-1:0] commit_ghr_q, commit_ghr_d;
  logic                   update_en_q, update_en_d;
  logic [INDEX_WIDTH-1:0] update_index_q, update_index_d;
  logic                   br_taken_q, br_taken_d;
  logic                   mispredict_q, mispredict_d;

  logic [ENTRY_W-1:0]     push_entry;
  logic [ENTRY_W-1:0]     head_entry;
  logic [INDEX_WIDTH-1:0] head_index;
  logic                   head_pred;
  logic                   q_full;
  logic                   q_empty;
  logic                   accept;
  logic                   resolve_eff;
  logic                   mispred_c;
  logic                   push;
  logic                   unused_pc;

  assign unused_pc = ^fetch_pc_i;

  assign rd_index_o    = fetch_pc_i[PC_LSB +: INDEX_WIDTH] ^ spec_ghr_q;
  assign pred_taken_o  = fetch_valid_i & pht_prediction_i;
  assign fetch_stall_o = q_full;

  assign head_index = head_entry[ENTRY_IDX_LSB +: INDEX_WIDTH];
  assign head_pred  = head_entry[ENTRY_PRED_BIT];

  assign accept      = fetch_valid_i & ~q_full;
  assign resolve_eff = resolve_valid_i & ~q_empty;
  assign mispred_c   = resolve_eff & (head_pred != resolve_taken_i);
  // Recovery beats a same-cycle fetch: that fetch is on the wrong path
  assign push        = accept & ~mispred_c;

  always_comb begin
    push_entry = '0;
    push_entry[ENTRY_IDX_LSB +: INDEX_WIDTH] = rd_index_o;
    push_entry[ENTRY_PRED_BIT]               = pht_prediction_i;
  end

  bp_inflight_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (resolve_eff),
    .flush_i (mispred_c),
    .wdata_i (push_entry),
    .head_o  (head_entry),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // Next-state for history registers and PHT update outputs
  always_comb begin
    spec_ghr_d     = spec_ghr_q;
    commit_ghr_d   = commit_ghr_q;
    update_en_d    = resolve_eff;
    update_index_d = update_index_q;
    br_taken_d     = br_taken_q;
    mispredict_d   = mispred_c;
    if (resolve_eff) begin
      commit_ghr_d   = {commit_ghr_q[INDEX_WIDTH-2:0], resolve_taken_i};
      update_index_d = head_index;
      br_taken_d     = resolve_taken_i;
    end
    if (mispred_c) begin
      spec_ghr_d = {commit_ghr_q[INDEX_WIDTH-2:0], resolve_taken_i};
    end else if (push) begin
      spec_ghr_d = {spec_ghr_q[INDEX_WIDTH-2:0], pht_prediction_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      spec_ghr_q     <= '0;
      commit_ghr_q   <= '0;
      update_en_q    <= 1'b0;
      update_index_q <= '0;
      br_taken_q     <= 1'b0;
      mispredict_q   <= 1'b0;
    end else begin
      spec_ghr_q     <= spec_ghr_d;
      commit_ghr_q   <= commit_ghr_d;
      update_en_q    <= update_en_d;
      update_index_q <= update_index_d;
      br_taken_q     <= br_taken_d;
      mispredict_q   <= mispredict_d;
    end
  end

  assign update_en_o    = update_en_q;
  assign update_index_o = update_index_q;
  assign br_taken_o     = br_taken_q;
  assign mispredict_o   = mispredict_q;

endmodule

// File: tb/tb_gshare_index_gen.sv
// Directed bench for gshare_index_gen with INDEX_WIDTH=4, PC_LSB=2, DEPTH=4.
module tb_gshare_index_gen;

  localparam int unsigned IW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          fetch_valid_i;
  logic [31:0]   fetch_pc_i;
  logic          pht_prediction_i;
  logic [IW-1:0] rd_index_o;
  logic          pred_taken_o;
  logic          fetch_stall_o;
  logic          resolve_valid_i;
  logic          resolve_taken_i;
  logic          update_en_o;
  logic [IW-1:0] update_index_o;
  logic          br_taken_o;
  logic          mispredict_o;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk_i = ~clk_i;

  gshare_index_gen #(
    .INDEX_WIDTH (IW),
    .PC_LSB      (2),
    .DEPTH       (4)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .fetch_valid_i    (fetch_valid_i),
    .fetch_pc_i       (fetch_pc_i),
    .pht_prediction_i (pht_prediction_i),
    .rd_index_o       (rd_index_o),
    .pred_taken_o     (pred_taken_o),
    .fetch_stall_o    (fetch_stall_o),
    .resolve_valid_i  (resolve_valid_i),
    .resolve_taken_i  (resolve_taken_i),
    .update_en_o      (update_en_o),
    .update_index_o   (update_index_o),
    .br_taken_o       (br_taken_o),
    .mispredict_o     (mispredict_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic pred, input logic rv, input logic rt);
    fetch_valid_i    = fv;
    pht_prediction_i = pred;
    resolve_valid_i  = rv;
    resolve_taken_i  = rt;
    #1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    fetch_valid_i    = 1'b0;
    pht_prediction_i = 1'b0;
    resolve_valid_i  = 1'b0;
    resolve_taken_i  = 1'b0;
    #1;
  endtask

  task automatic check_update(input string tag, input logic en, input logic [IW-1:0] idx,
                              input logic tk, input logic mis);
    check_eq({tag, "_en"},  32'(update_en_o),    32'(en));
    check_eq({tag, "_idx"}, 32'(update_index_o), 32'(idx));
    check_eq({tag, "_tk"},  32'(br_taken_o),     32'(tk));
    check_eq({tag, "_mis"}, 32'(mispredict_o),   32'(mis));
  endtask

  initial begin
    rst_i            = 1'b0;
    fetch_valid_i    = 1'b0;
    fetch_pc_i       = 32'h34;
    pht_prediction_i = 1'b0;
    resolve_valid_i  = 1'b0;
    resolve_taken_i  = 1'b0;
    #2;
    check_update("rst", 1'b0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check_eq("rst_idx",   32'(rd_index_o),    32'hD);
    check_eq("rst_stall", 32'(fetch_stall_o), 32'h0);

    // Three predictions 1,0,1 at the same PC
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("f1_idx",  32'(rd_index_o),   32'hD);
    check_eq("f1_pred", 32'(pred_taken_o), 32'h1);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("f2_idx",  32'(rd_index_o),   32'hC);
    check_eq("f2_pred", 32'(pred_taken_o), 32'h0);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("f3_idx", 32'(rd_index_o), 32'hF);
    step();
    check_eq("ghr0101_idx", 32'(rd_index_o),    32'h8);
    check_eq("q3_stall",    32'(fetch_stall_o), 32'h0);

    // Correct resolve of the oldest entry
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check_update("res1", 1'b1, 4'hD, 1'b1, 1'b0);

    // Mispredict with a same-cycle fetch: flush, fetch dropped, GHR repaired to 0011
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    step();
    check_update("res2", 1'b1, 4'hC, 1'b1, 1'b1);
    check_eq("repair_idx", 32'(rd_index_o), 32'hE);
    step();
    check_eq("pulse_en",  32'(update_en_o),  32'h0);
    check_eq("pulse_mis", 32'(mispredict_o), 32'h0);
    // Queue is empty after flush: resolve ignored
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_eq("flush_empty_en", 32'(update_en_o), 32'h0);
    check_eq("flush_idx",      32'(rd_index_o),  32'hE);

    // Fill the queue with not-taken predictions: indices E,B,1,5
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("fill0_idx", 32'(rd_index_o), 32'hE);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("fill1_idx", 32'(rd_index_o), 32'hB);
    step();
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("fill2_idx", 32'(rd_index_o), 32'h1);
    step();
    check_eq("fill3_stall", 32'(fetch_stall_o), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("fill3_idx", 32'(rd_index_o), 32'h5);
    step();
    check_eq("full_stall", 32'(fetch_stall_o), 32'h1);
    check_eq("full_idx",   32'(rd_index_o),    32'hD);

    // Fetch while full: not pushed, GHR unchanged
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("stalled_idx", 32'(rd_index_o), 32'hD);

    // Pop plus fetch while full: pop happens, no push
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("popfetch_stall", 32'(fetch_stall_o), 32'h1);
    step();
    check_update("popfetch", 1'b1, 4'hE, 1'b0, 1'b0);
    check_eq("popfetch_stall_after", 32'(fetch_stall_o), 32'h0);
    check_eq("popfetch_idx",         32'(rd_index_o),    32'hD);

    // Refill the free slot with a taken prediction at index D
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check_eq("refill_stall", 32'(fetch_stall_o), 32'h1);
    check_eq("refill_idx",   32'(rd_index_o),    32'hC);

    // Drain in order, all correct: B,1,5 (not taken) then D (taken)
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_update("drain0", 1'b1, 4'hB, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_update("drain1", 1'b1, 4'h1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    check_update("drain2", 1'b1, 4'h5, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check_update("drain3", 1'b1, 4'hD, 1'b1, 1'b0);

    // Resolve on empty queue
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check_eq("empty_res_en",  32'(update_en_o),  32'h0);
    check_eq("empty_res_mis", 32'(mispredict_o), 32'h0);

    // Push four taken (C,E,A,2), resolve one, then reset with three queued
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("r0_idx", 32'(rd_index_o), 32'hC);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("r1_idx", 32'(rd_index_o), 32'hE);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("r2_idx", 32'(rd_index_o), 32'hA);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("r3_idx", 32'(rd_index_o), 32'h2);
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check_update("pre_rst", 1'b1, 4'hC, 1'b1, 1'b0);
    rst_i = 1'b0;
    #1;
    check_update("mid_rst", 1'b0, 4'h0, 1'b0, 1'b0);
    check_eq("mid_rst_stall", 32'(fetch_stall_o), 32'h0);
    check_eq("mid_rst_idx",   32'(rd_index_o),    32'hD);
    step();
    rst_i = 1'b1;
    #1;
    // Queue discarded: resolve after reset is ignored
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check_eq("post_rst_en", 32'(update_en_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
